// File: rtl/result_slot_ctrl_if.sv
// Producer/consumer/bank signal bundle for result_slot_ctrl.
// slave = the controller; master = the surrounding producer, consumer and register bank.
interface result_slot_ctrl_if;
  logic        push_valid;
  logic        push_ready;
  logic [63:0] push_data;
  logic [2:0]  reg_en;
  logic [63:0] reg_wdata;
  logic [63:0] reg_q0;
  logic [63:0] reg_q1;
  logic [63:0] reg_q2;
  logic        rd_req;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic [1:0]  count;
  logic        full;
  logic        empty;

  modport slave (
    input  push_valid, push_data, reg_q0, reg_q1, reg_q2, rd_req,
    output push_ready, reg_en, reg_wdata, rd_ack, rd_data, count, full, empty
  );

  modport master (
    output push_valid, push_data, reg_q0, reg_q1, reg_q2, rd_req,
    input  push_ready, reg_en, reg_wdata, rd_ack, rd_data, count, full, empty
  );
endinterface

// File: rtl/result_slot_ctrl.sv
// 3-deep circular result queue over an external 64-bit register bank, drained as lo/hi 32-bit words.
// Optional feature: define RESULT_SLOT_FLUSH_EN to add a synchronous flush input.
module result_slot_ctrl (
  input  logic clk,
  input  logic reset_n,
`ifdef RESULT_SLOT_FLUSH_EN
  input  logic flush,
`endif
  result_slot_ctrl_if.slave bus
);

  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_e;

  logic [1:0]  r_wr_ptr,  w_wr_ptr_nxt;
  logic [1:0]  r_rd_ptr,  w_rd_ptr_nxt;
  logic [1:0]  r_count,   w_count_nxt;
  half_e       r_half,    w_half_nxt;
  logic        r_rd_ack,  w_rd_ack_nxt;
  logic [31:0] r_rd_data, w_rd_data_nxt;

  logic        w_full;
  logic        w_empty;
  logic        w_push_acc;
  logic        w_rd_acc;
  logic        w_pop;
  logic        w_flush;
  logic [63:0] w_slot;
  logic [2:0]  w_reg_en;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

`ifdef RESULT_SLOT_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_full     = (r_count == 2'd3);
  assign w_empty    = (r_count == 2'd0);
  assign w_push_acc = bus.push_valid & ~w_full;
  assign w_rd_acc   = bus.rd_req & ~w_empty;
  assign w_pop      = w_rd_acc & (r_half == HALF_HI);

  always_comb begin
    w_slot = bus.reg_q2;
    case (r_rd_ptr)
      2'd0:    w_slot = bus.reg_q0;
      2'd1:    w_slot = bus.reg_q1;
      default: w_slot = bus.reg_q2;
    endcase
  end

  // Load enable follows the accept even when a flush discards the push.
  always_comb begin
    w_reg_en = 3'b000;
    if (w_push_acc) begin
      case (r_wr_ptr)
        2'd0:    w_reg_en = 3'b001;
        2'd1:    w_reg_en = 3'b010;
        default: w_reg_en = 3'b100;
      endcase
    end
  end

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path can infer a latch.
    w_wr_ptr_nxt  = r_wr_ptr;
    w_rd_ptr_nxt  = r_rd_ptr;
    w_count_nxt   = r_count;
    w_half_nxt    = r_half;
    w_rd_ack_nxt  = 1'b0;
    w_rd_data_nxt = r_rd_data;

    if (w_push_acc) w_wr_ptr_nxt = ptr_inc(r_wr_ptr);

    if (w_rd_acc) begin
      w_rd_ack_nxt  = 1'b1;
      w_rd_data_nxt = (r_half == HALF_HI) ? w_slot[63:32] : w_slot[31:0];
      w_half_nxt    = (r_half == HALF_HI) ? HALF_LO : HALF_HI;
      if (w_pop) w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
    end

    case ({w_push_acc, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase

    // Flush wins over everything except the read word, which is held.
    if (w_flush) begin
      w_wr_ptr_nxt = 2'd0;
      w_rd_ptr_nxt = 2'd0;
      w_count_nxt  = 2'd0;
      w_half_nxt   = HALF_LO;
      w_rd_ack_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= 2'd0;
      r_rd_ptr  <= 2'd0;
      r_count   <= 2'd0;
      r_half    <= HALF_LO;
      r_rd_ack  <= 1'b0;
      r_rd_data <= 32'd0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_half    <= w_half_nxt;
      r_rd_ack  <= w_rd_ack_nxt;
      r_rd_data <= w_rd_data_nxt;
    end
  end

  assign bus.push_ready = ~w_full;
  assign bus.reg_en     = w_reg_en;
  assign bus.reg_wdata  = bus.push_data;
  assign bus.rd_ack     = r_rd_ack;
  assign bus.rd_data    = r_rd_data;
  assign bus.count      = r_count;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;

endmodule
